// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: MSB-first serial pattern transmitter with repeats and inter-frame gaps
module seq_pattern_tx #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   input  logic [CNT_W-1:0]   reps,
   input  logic [CNT_W-1:0]   gap,
   output logic               ser_out,
   output logic               ser_valid,
   output logic               busy,
   output logic               done,
   output logic               err
);
   typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
   state_t             state_q;
   logic [MAX_LEN-1:0] pat_q, sh_q, pat_al;
   logic [LEN_W-1:0]   len_q, bit_idx_q;
   logic [CNT_W-1:0]   reps_q, gap_q, rep_cnt_q, gap_cnt_q;
   logic               ser_out_q, ser_valid_q, busy_q, done_q, err_q;
   logic               legal, last_bit, last_rep;
   // request legality, MSB-aligned frame, and end-of-frame / end-of-transfer decode
   always_comb begin
      legal    = len != '0 && len <= LEN_W'(MAX_LEN) && reps != '0;
      pat_al   = pattern << (LEN_W'(MAX_LEN) - len);
      last_bit = bit_idx_q == len_q - LEN_W'(1);
      last_rep = rep_cnt_q == reps_q - CNT_W'(1);
   end
   // FSM with outputs registered for the state being entered
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         pat_q       <= '0;
         sh_q        <= '0;
         len_q       <= '0;
         reps_q      <= '0;
         gap_q       <= '0;
         bit_idx_q   <= '0;
         rep_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         case (state_q)
            IDLE:
               if (start && legal) begin
                  pat_q       <= pat_al;
                  sh_q        <= pat_al;
                  len_q       <= len;
                  reps_q      <= reps;
                  gap_q       <= gap;
                  bit_idx_q   <= '0;
                  rep_cnt_q   <= '0;
                  ser_out_q   <= pat_al[MAX_LEN-1];
                  ser_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= SHIFT;
               end else begin
                  err_q <= start;
               end
            SHIFT:
               if (abort) begin
                  state_q <= IDLE;
               end else if (!last_bit) begin
                  bit_idx_q   <= bit_idx_q + LEN_W'(1);
                  sh_q        <= sh_q << 1;
                  ser_out_q   <= sh_q[MAX_LEN-2];
                  ser_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
               end else if (last_rep) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  rep_cnt_q <= rep_cnt_q + CNT_W'(1);
                  bit_idx_q <= '0;
                  busy_q    <= 1'b1;
                  if (gap_q == '0) begin
                     sh_q        <= pat_q;
                     ser_out_q   <= pat_q[MAX_LEN-1];
                     ser_valid_q <= 1'b1;
                  end else begin
                     gap_cnt_q <= gap_q;
                     state_q   <= GAP;
                  end
               end
            GAP:
               if (abort) begin
                  state_q <= IDLE;
               end else if (gap_cnt_q == CNT_W'(1)) begin
                  sh_q        <= pat_q;
                  ser_out_q   <= pat_q[MAX_LEN-1];
                  ser_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= SHIFT;
               end else begin
                  gap_cnt_q <= gap_cnt_q - CNT_W'(1);
                  busy_q    <= 1'b1;
               end
            DONE:
               state_q <= IDLE;
            default:
               state_q <= IDLE;
         endcase
      end
   end
   assign ser_out   = ser_out_q;
   assign ser_valid = ser_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed vector table plus abort and async-reset sequences
module tb_seq_pattern_tx;
   logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic [7:0] pattern = '0;
   logic [3:0] len = '0, reps = '0, gap = '0;
   logic       ser_out, ser_valid, busy, done, err;
   int         checks = 0, failures = 0;

   typedef struct {
      logic       st;
      logic [7:0] pat;
      logic [3:0] len, reps, gap;
      logic [4:0] exp;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   seq_pattern_tx dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .pattern(pattern), .len(len), .reps(reps), .gap(gap),
      .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .done(done), .err(err)
   );

   // expected vector order: {ser_out, ser_valid, busy, done, err}
   task automatic add(input logic st, input logic [7:0] p, input logic [3:0] l, r, g, input logic [4:0] e);
      vec_t v;
      v.st = st; v.pat = p; v.len = l; v.reps = r; v.gap = g; v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [4:0] e);
      logic [4:0] got;
      got = {ser_out, ser_valid, busy, done, err};
      checks++;
      if (got !== e) begin
         failures++;
         $display("FAIL %s: got out/valid/busy/done/err=%b expected %b", name, got, e);
      end
   endtask

   task automatic step(input logic st, input logic ab, input logic [4:0] e, input string name);
      start = st;
      abort = ab;
      @(posedge clk);
      @(negedge clk);
      check(name, e);
   endtask

   task automatic scen1(input string tag);
      pattern = 8'h0C; len = 4'd4; reps = 4'd1; gap = 4'd0;
      step(1'b1, 1'b0, 5'b11100, {tag, "_b1"});
      step(1'b0, 1'b0, 5'b11100, {tag, "_b2"});
      step(1'b0, 1'b0, 5'b01100, {tag, "_b3"});
      step(1'b0, 1'b0, 5'b01100, {tag, "_b4"});
      step(1'b0, 1'b0, 5'b00010, {tag, "_done"});
      step(1'b0, 1'b0, 5'b00000, {tag, "_idle"});
   endtask

   initial begin
      logic [12:0] sv2, so2;
      logic [7:0]  a5;
      sv2 = 13'b1110011100111;
      so2 = 13'b1010010100101;
      a5  = 8'hA5;

      add(1'b1, 8'h0C, 4'd4, 4'd1, 4'd0, 5'b11100);
      add(1'b0, 8'h0C, 4'd4, 4'd1, 4'd0, 5'b11100);
      add(1'b0, 8'h0C, 4'd4, 4'd1, 4'd0, 5'b01100);
      add(1'b0, 8'h0C, 4'd4, 4'd1, 4'd0, 5'b01100);
      add(1'b0, 8'h0C, 4'd4, 4'd1, 4'd0, 5'b00010);
      add(1'b0, 8'h0C, 4'd4, 4'd1, 4'd0, 5'b00000);
      for (int i = 0; i < 13; i++)
         add(i == 0, 8'h05, 4'd3, 4'd3, 4'd2, {so2[12-i], sv2[12-i], 3'b100});
      add(1'b0, 8'h05, 4'd3, 4'd3, 4'd2, 5'b00010);
      add(1'b0, 8'h05, 4'd3, 4'd3, 4'd2, 5'b00000);
      for (int i = 0; i < 16; i++)
         add(i == 0, 8'hA5, 4'd8, 4'd2, 4'd0, {a5[7 - (i % 8)], 4'b1100});
      add(1'b0, 8'hA5, 4'd8, 4'd2, 4'd0, 5'b00010);
      add(1'b0, 8'hA5, 4'd8, 4'd2, 4'd0, 5'b00000);
      add(1'b1, 8'h0C, 4'd0, 4'd1, 4'd0, 5'b00001);
      add(1'b0, 8'h0C, 4'd0, 4'd1, 4'd0, 5'b00000);
      add(1'b1, 8'h0C, 4'd9, 4'd1, 4'd0, 5'b00001);
      add(1'b0, 8'h0C, 4'd9, 4'd1, 4'd0, 5'b00000);
      add(1'b1, 8'h0C, 4'd4, 4'd0, 4'd0, 5'b00001);
      add(1'b0, 8'h0C, 4'd4, 4'd0, 4'd0, 5'b00000);

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset", 5'b00000);
      reset_n = 1'b1;
      step(1'b0, 1'b1, 5'b00000, "idle_abort");

      for (int i = 0; i < tbl.size(); i++) begin
         pattern = tbl[i].pat;
         len     = tbl[i].len;
         reps    = tbl[i].reps;
         gap     = tbl[i].gap;
         step(tbl[i].st, 1'b0, tbl[i].exp, $sformatf("row%0d", i));
      end

      pattern = 8'h05; len = 4'd3; reps = 4'd3; gap = 4'd2;
      step(1'b1, 1'b0, 5'b11100, "s5_c1");
      step(1'b0, 1'b0, 5'b01100, "s5_c2");
      pattern = 8'hFF; len = 4'd8; reps = 4'd1; gap = 4'd0;
      step(1'b1, 1'b0, 5'b11100, "s5_c3");
      step(1'b0, 1'b0, 5'b00100, "s5_gap");
      step(1'b0, 1'b1, 5'b00000, "s5_abort");
      step(1'b0, 1'b0, 5'b00000, "s5_nodone1");
      step(1'b0, 1'b0, 5'b00000, "s5_nodone2");
      scen1("s5_new");

      pattern = 8'h0C; len = 4'd4; reps = 4'd1; gap = 4'd0;
      step(1'b1, 1'b0, 5'b11100, "s6_b1");
      step(1'b0, 1'b0, 5'b11100, "s6_b2");
      #1 reset_n = 1'b0;
      #1 check("s6_async", 5'b00000);
      @(posedge clk);
      @(negedge clk);
      check("s6_hold", 5'b00000);
      reset_n = 1'b1;
      step(1'b0, 1'b0, 5'b00000, "s6_idle1");
      step(1'b0, 1'b0, 5'b00000, "s6_idle2");
      scen1("s6_new");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
